// File: rtl/ym_write_pacer.sv
// ym_write_pacer: buffers complete YM2612 register writes from the host and
// replays each one on the chip-array bus as an address strobe followed by a
// data strobe, inserting the settle time the FM cores need between them.
// An optional last-address cache lets back-to-back writes to the same
// {chip, port, reg} skip the address phase.
module ym_write_pacer #(
  parameter int FIFO_DEPTH = 16,
  parameter int STROBE_LEN = 2,
  parameter int ADDR_WAIT  = 17,
  parameter int DATA_WAIT  = 83
) (
  input  logic                        clk,
  input  logic                        rst_n,
  input  logic                        i_in_valid,
  output logic                        o_in_ready,
  input  logic [4:0]                  i_in_chip,
  input  logic                        i_in_port,
  input  logic [7:0]                  i_in_reg,
  input  logic [7:0]                  i_in_data,
  input  logic                        i_skip_addr_en,
  output logic [4:0]                  o_cs,
  output logic [1:0]                  o_addr,
  output logic [7:0]                  o_din,
  output logic                        o_wr_n,
  output logic [$clog2(FIFO_DEPTH):0] o_level,
  output logic                        o_busy
);

  localparam int AW   = $clog2(FIFO_DEPTH);
  localparam int LW   = AW + 1;
  localparam int WMAX = (ADDR_WAIT > DATA_WAIT) ? ADDR_WAIT : DATA_WAIT;
  localparam int CMAX = (WMAX > STROBE_LEN) ? WMAX : STROBE_LEN;
  localparam int CW   = $clog2(CMAX + 1);

  // Counters load "cycles - 1" on state entry and leave the state at zero.
  localparam logic [CW-1:0] C_STROBE = CW'(STROBE_LEN - 1);
  localparam logic [CW-1:0] C_AWAIT  = CW'(ADDR_WAIT - 1);
  localparam logic [CW-1:0] C_DWAIT  = CW'(DATA_WAIT - 1);

  typedef enum logic [2:0] {
    S_IDLE     = 3'd0,
    S_A_SETUP  = 3'd1,
    S_A_STROBE = 3'd2,
    S_A_WAIT   = 3'd3,
    S_D_SETUP  = 3'd4,
    S_D_STROBE = 3'd5,
    S_D_WAIT   = 3'd6
  } state_t;

  // FIFO entry layout: {chip[21:17], port[16], reg[15:8], data[7:0]}
  logic [21:0]   r_mem [FIFO_DEPTH];
  logic [AW-1:0] r_wr_ptr;
  logic [AW-1:0] r_rd_ptr;
  logic [LW-1:0] r_level;
  logic          r_in_ready;

  state_t        r_state;
  logic [CW-1:0] r_cnt;
  logic [4:0]    r_cs;
  logic [1:0]    r_addr;
  logic [7:0]    r_din;
  logic          r_wr_n;
  logic          r_busy;
  logic [21:0]   r_cur;
  logic [13:0]   r_cache;
  logic          r_cache_vld;

  logic [21:0]   w_head;
  logic [4:0]    w_head_chip;
  logic          w_head_port;
  logic [7:0]    w_head_reg;
  logic [7:0]    w_head_data;
  logic          w_push;
  logic          w_can_pop;
  logic          w_dispatch_pt;
  logic          w_pop;
  logic          w_next_idle;
  logic          w_cache_hit;
  logic [LW-1:0] w_level_next;

  assign w_head      = r_mem[r_rd_ptr];
  assign w_head_chip = w_head[21:17];
  assign w_head_port = w_head[16];
  assign w_head_reg  = w_head[15:8];
  assign w_head_data = w_head[7:0];

  // Full blocks pushes even if a pop happens in the same cycle.
  assign w_push    = i_in_valid & r_in_ready;
  assign w_can_pop = (r_level != {LW{1'b0}});

  // IDLE and the last D_WAIT cycle are the only points where a new entry is taken.
  assign w_dispatch_pt = (r_state == S_IDLE) ||
                         ((r_state == S_D_WAIT) && (r_cnt == {CW{1'b0}}));
  assign w_pop         = w_dispatch_pt & w_can_pop;
  assign w_next_idle   = w_dispatch_pt & (~w_can_pop | (w_head_chip == 5'd0));
  assign w_cache_hit   = i_skip_addr_en & r_cache_vld &
                         ({w_head_chip, w_head_port, w_head_reg} == r_cache);
  assign w_level_next  = r_level + LW'(w_push) - LW'(w_pop);

  // FIFO storage; contents need no reset since level gates every read.
  always_ff @(posedge clk) begin
    if (w_push) begin
      r_mem[r_wr_ptr] <= {i_in_chip, i_in_port, i_in_reg, i_in_data};
    end
  end

  // FIFO pointers, occupancy and the registered ready flag.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_wr_ptr   <= {AW{1'b0}};
      r_rd_ptr   <= {AW{1'b0}};
      r_level    <= {LW{1'b0}};
      r_in_ready <= 1'b1;
    end else begin
      if (w_push) begin
        r_wr_ptr <= r_wr_ptr + AW'(1'b1);
      end
      if (w_pop) begin
        r_rd_ptr <= r_rd_ptr + AW'(1'b1);
      end
      r_level    <= w_level_next;
      r_in_ready <= (w_level_next != LW'(FIFO_DEPTH));
    end
  end

  // Write sequencer: bus outputs are set on the edge that enters each state.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state     <= S_IDLE;
      r_cnt       <= {CW{1'b0}};
      r_cs        <= 5'd0;
      r_addr      <= 2'd0;
      r_din       <= 8'd0;
      r_wr_n      <= 1'b1;
      r_busy      <= 1'b0;
      r_cur       <= 22'd0;
      r_cache     <= 14'd0;
      r_cache_vld <= 1'b0;
    end else begin
      r_busy <= ~w_next_idle | (w_level_next != {LW{1'b0}});
      case (r_state)
        S_IDLE, S_D_WAIT: begin
          if ((r_state == S_D_WAIT) && (r_cnt != {CW{1'b0}})) begin
            r_cnt <= r_cnt - CW'(1'b1);
          end else if (w_can_pop) begin
            r_cur <= w_head;
            if (w_head_chip == 5'd0) begin
              // Chip 0 is a discard: consume it without touching bus or cache.
              r_state <= S_IDLE;
              r_cs    <= 5'd0;
              r_wr_n  <= 1'b1;
            end else if (w_cache_hit) begin
              r_state <= S_D_SETUP;
              r_cs    <= w_head_chip;
              r_addr  <= {w_head_port, 1'b1};
              r_din   <= w_head_data;
            end else begin
              r_state <= S_A_SETUP;
              r_cs    <= w_head_chip;
              r_addr  <= {w_head_port, 1'b0};
              r_din   <= w_head_reg;
            end
          end else begin
            r_state <= S_IDLE;
            r_cs    <= 5'd0;
            r_wr_n  <= 1'b1;
          end
        end
        S_A_SETUP: begin
          r_state <= S_A_STROBE;
          r_wr_n  <= 1'b0;
          r_cnt   <= C_STROBE;
        end
        S_A_STROBE: begin
          if (r_cnt != {CW{1'b0}}) begin
            r_cnt <= r_cnt - CW'(1'b1);
          end else begin
            r_state     <= S_A_WAIT;
            r_wr_n      <= 1'b1;
            r_cs        <= 5'd0;
            r_cnt       <= C_AWAIT;
            r_cache     <= r_cur[21:8];
            r_cache_vld <= 1'b1;
          end
        end
        S_A_WAIT: begin
          if (r_cnt != {CW{1'b0}}) begin
            r_cnt <= r_cnt - CW'(1'b1);
          end else begin
            r_state <= S_D_SETUP;
            r_cs    <= r_cur[21:17];
            r_addr  <= {r_cur[16], 1'b1};
            r_din   <= r_cur[7:0];
          end
        end
        S_D_SETUP: begin
          r_state <= S_D_STROBE;
          r_wr_n  <= 1'b0;
          r_cnt   <= C_STROBE;
        end
        S_D_STROBE: begin
          if (r_cnt != {CW{1'b0}}) begin
            r_cnt <= r_cnt - CW'(1'b1);
          end else begin
            r_state <= S_D_WAIT;
            r_wr_n  <= 1'b1;
            r_cs    <= 5'd0;
            r_cnt   <= C_DWAIT;
          end
        end
        default: begin
          r_state <= S_IDLE;
          r_wr_n  <= 1'b1;
          r_cs    <= 5'd0;
          r_cnt   <= {CW{1'b0}};
        end
      endcase
    end
  end

  assign o_in_ready = r_in_ready;
  assign o_level    = r_level;
  assign o_cs       = r_cs;
  assign o_addr     = r_addr;
  assign o_din      = r_din;
  assign o_wr_n     = r_wr_n;
  assign o_busy     = r_busy;

endmodule

// File: tb/tb_ym_write_pacer.sv
// Directed bench for ym_write_pacer: a negedge bus monitor logs every wr_n
// strobe (bus word, start cycle, length); tests compare the log against
// hand-computed bus words and cycle offsets at default parameters.
`timescale 1ns/1ps
module tb_ym_write_pacer;

  logic       clk = 1'b0;
  logic       rst_n;
  logic       i_in_valid;
  logic       o_in_ready;
  logic [4:0] i_in_chip;
  logic       i_in_port;
  logic [7:0] i_in_reg;
  logic [7:0] i_in_data;
  logic       i_skip_addr_en;
  logic [4:0] o_cs;
  logic [1:0] o_addr;
  logic [7:0] o_din;
  logic       o_wr_n;
  logic [4:0] o_level;
  logic       o_busy;

  int n_vec = 0;
  int n_err = 0;

  // strobe log written by the monitor
  int          cyc = 0;
  int          busy_fall = 0;
  int          stab_err = 0;
  logic        prev_wr_n = 1'b1;
  logic        prev_busy = 1'b0;
  logic [14:0] q_bus[$];
  int          q_start[$];
  int          q_len[$];

  ym_write_pacer dut (
    .clk            (clk),
    .rst_n          (rst_n),
    .i_in_valid     (i_in_valid),
    .o_in_ready     (o_in_ready),
    .i_in_chip      (i_in_chip),
    .i_in_port      (i_in_port),
    .i_in_reg       (i_in_reg),
    .i_in_data      (i_in_data),
    .i_skip_addr_en (i_skip_addr_en),
    .o_cs           (o_cs),
    .o_addr         (o_addr),
    .o_din          (o_din),
    .o_wr_n         (o_wr_n),
    .o_level        (o_level),
    .o_busy         (o_busy)
  );

  always #5 clk = ~clk;

  // Bus monitor: log strobes, their length, bus stability and busy falls.
  always @(negedge clk) begin
    cyc = cyc + 1;
    if (!o_wr_n) begin
      if (prev_wr_n) begin
        q_bus.push_back({o_cs, o_addr, o_din});
        q_start.push_back(cyc);
        q_len.push_back(1);
      end else if (q_len.size() != 0) begin
        q_len[q_len.size()-1] = q_len[q_len.size()-1] + 1;
        if ({o_cs, o_addr, o_din} != q_bus[q_bus.size()-1]) stab_err = stab_err + 1;
      end
    end
    if (prev_busy && !o_busy) busy_fall = cyc;
    prev_wr_n = o_wr_n;
    prev_busy = o_busy;
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_vec++;
    if (obs !== exp) begin
      n_err++;
      $display("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(negedge clk);
    #1;
  endtask

  function automatic logic [18:0] ew(input logic [4:0] c, input logic [1:0] a, input logic [7:0] d);
    return {c, a, d, 4'd2};
  endfunction

  function automatic logic [18:0] sw(input int idx);
    if (idx < q_bus.size()) return {q_bus[idx], 4'(q_len[idx])};
    else return 19'h7FFFF;
  endfunction

  function automatic int rel(input int idx);
    if (idx < q_start.size() && q_start.size() > 0) return q_start[idx] - q_start[0];
    else return -1;
  endfunction

  function automatic int busy_rel();
    if (q_start.size() > 0) return busy_fall - q_start[0];
    else return -1;
  endfunction

  task automatic clear_log();
    q_bus.delete();
    q_start.delete();
    q_len.delete();
  endtask

  task automatic push(input logic [4:0] c, input logic p, input logic [7:0] r, input logic [7:0] d);
    int n;
    i_in_chip  = c;
    i_in_port  = p;
    i_in_reg   = r;
    i_in_data  = d;
    i_in_valid = 1'b1;
    n = 0;
    while (!o_in_ready && n < 400) begin
      tick();
      n++;
    end
    chk("push_ready", o_in_ready, 1);
    tick();
    i_in_valid = 1'b0;
  endtask

  task automatic wait_idle(input string tag, input int budget);
    int n;
    n = 0;
    while (o_busy && n < budget) begin
      tick();
      n++;
    end
    chk(tag, o_busy, 0);
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int n;
    rst_n          = 1'b0;
    i_in_valid     = 1'b1;
    i_in_chip      = 5'd7;
    i_in_port      = 1'b0;
    i_in_reg       = 8'h11;
    i_in_data      = 8'h22;
    i_skip_addr_en = 1'b0;

    // ---- reset state, pushes ignored in reset ----
    repeat (3) tick();
    chk("rst_cs", o_cs, 0);
    chk("rst_addr", o_addr, 0);
    chk("rst_din", o_din, 0);
    chk("rst_wr_n", o_wr_n, 1);
    chk("rst_level", o_level, 0);
    chk("rst_busy", o_busy, 0);
    chk("rst_ready", o_in_ready, 1);
    i_in_valid = 1'b0;
    rst_n = 1'b1;
    tick();
    chk("rst_nopush", o_level, 0);

    // ---- test 1: single full write, latency and period ----
    clear_log();
    push(5'd2, 1'b1, 8'h28, 8'hF0);
    chk("t1_level", o_level, 1);
    chk("t1_busy", o_busy, 1);
    tick();
    chk("t1_setup_bus", {o_cs, o_addr, o_din}, {5'd2, 2'b10, 8'h28});
    chk("t1_setup_wr", o_wr_n, 1);
    tick();
    chk("t1_strobe_wr", o_wr_n, 0);
    wait_idle("t1_idle", 300);
    chk("t1_count", q_bus.size(), 2);
    chk("t1_addr", sw(0), ew(5'd2, 2'b10, 8'h28));
    chk("t1_data", sw(1), ew(5'd2, 2'b11, 8'hF0));
    chk("t1_data_off", rel(1), 20);
    chk("t1_busy_off", busy_rel(), 105);

    // ---- test 2: 20 back-to-back writes through a 16-deep FIFO ----
    clear_log();
    for (int i = 0; i < 20; i++) begin
      push(5'(i % 3 + 1), 1'(i % 2), 8'(8'h30 + i), 8'(8'hA0 + i));
      if (i == 16) begin
        chk("t2_full_level", o_level, 16);
        chk("t2_full_ready", o_in_ready, 0);
      end
    end
    wait_idle("t2_idle", 2500);
    chk("t2_count", q_bus.size(), 40);
    for (int i = 0; i < 20; i++) begin
      chk("t2_addr", sw(2*i), ew(5'(i % 3 + 1), {1'(i % 2), 1'b0}, 8'(8'h30 + i)));
      chk("t2_data", sw(2*i+1), ew(5'(i % 3 + 1), {1'(i % 2), 1'b1}, 8'(8'hA0 + i)));
      chk("t2_addr_off", rel(2*i), 106*i);
      chk("t2_data_off", rel(2*i+1), 106*i + 20);
    end
    chk("t2_busy_off", busy_rel(), 2119);

    // ---- test 3: address-phase skip on repeated register ----
    clear_log();
    i_skip_addr_en = 1'b1;
    push(5'd1, 1'b0, 8'h2A, 8'h10);
    push(5'd1, 1'b0, 8'h2A, 8'h20);
    push(5'd1, 1'b0, 8'h2A, 8'h30);
    push(5'd1, 1'b0, 8'h2B, 8'h40);
    wait_idle("t3_idle", 600);
    chk("t3_count", q_bus.size(), 6);
    chk("t3_a0", sw(0), ew(5'd1, 2'b00, 8'h2A));
    chk("t3_d0", sw(1), ew(5'd1, 2'b01, 8'h10));
    chk("t3_d1", sw(2), ew(5'd1, 2'b01, 8'h20));
    chk("t3_d2", sw(3), ew(5'd1, 2'b01, 8'h30));
    chk("t3_a3", sw(4), ew(5'd1, 2'b00, 8'h2B));
    chk("t3_d3", sw(5), ew(5'd1, 2'b01, 8'h40));
    chk("t3_off_d0", rel(1), 20);
    chk("t3_off_d1", rel(2), 106);
    chk("t3_off_d2", rel(3), 192);
    chk("t3_off_a3", rel(4), 278);
    chk("t3_off_d3", rel(5), 298);
    chk("t3_busy_off", busy_rel(), 383);

    // ---- test 4: chip 0 discard leaves cache intact ----
    clear_log();
    push(5'd3, 1'b1, 8'h40, 8'h11);
    push(5'd0, 1'b0, 8'h55, 8'h66);
    push(5'd3, 1'b1, 8'h40, 8'h22);
    wait_idle("t4_idle", 400);
    chk("t4_count", q_bus.size(), 3);
    chk("t4_a0", sw(0), ew(5'd3, 2'b10, 8'h40));
    chk("t4_d0", sw(1), ew(5'd3, 2'b11, 8'h11));
    chk("t4_d2", sw(2), ew(5'd3, 2'b11, 8'h22));
    chk("t4_off_d2", rel(2), 107);
    chk("t4_busy_off", busy_rel(), 192);

    // ---- test 5: reset during data strobe with 5 entries queued ----
    clear_log();
    for (int i = 0; i < 6; i++) push(5'd4, 1'b0, 8'(8'h50 + i), 8'(i));
    n = 0;
    while (!(o_wr_n == 1'b0 && o_addr == 2'b01) && n < 60) begin
      tick();
      n++;
    end
    chk("t5_in_dstrobe", {o_wr_n, o_addr}, {1'b0, 2'b01});
    chk("t5_queued", o_level, 5);
    rst_n = 1'b0;
    #1;
    chk("t5_rst_wr_n", o_wr_n, 1);
    chk("t5_rst_cs", o_cs, 0);
    chk("t5_rst_level", o_level, 0);
    chk("t5_rst_busy", o_busy, 0);
    i_in_chip  = 5'd9;
    i_in_valid = 1'b1;
    tick();
    tick();
    i_in_valid = 1'b0;
    chk("t5_rst_nopush", o_level, 0);
    rst_n = 1'b1;
    tick();
    clear_log();
    push(5'd4, 1'b0, 8'h50, 8'hEE);
    wait_idle("t5_idle", 300);
    chk("t5_count", q_bus.size(), 2);
    chk("t5_a0", sw(0), ew(5'd4, 2'b00, 8'h50));
    chk("t5_d0", sw(1), ew(5'd4, 2'b01, 8'hEE));

    // ---- test 6: push while full in the same cycle as a pop ----
    i_skip_addr_en = 1'b0;
    clear_log();
    for (int i = 0; i < 17; i++) push(5'd5, 1'b1, 8'(i), 8'(i));
    n = 0;
    while (!(o_wr_n == 1'b0 && o_addr == 2'b11) && n < 60) begin
      tick();
      n++;
    end
    chk("t6_in_dstrobe", {o_wr_n, o_addr}, {1'b0, 2'b11});
    repeat (84) tick();
    i_in_chip  = 5'd6;
    i_in_valid = 1'b1;
    chk("t6_full_ready", o_in_ready, 0);
    chk("t6_full_level", o_level, 16);
    tick();
    i_in_valid = 1'b0;
    chk("t6_after_level", o_level, 15);
    chk("t6_after_ready", o_in_ready, 1);
    rst_n = 1'b0;
    tick();
    rst_n = 1'b1;
    tick();

    chk("bus_stable", stab_err, 0);
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
